i2s_tx_sched: RTL and testbench

Sample-source scheduler in front of the `i2s_bi` transmit side. It shares the transmitter's once-per-frame sample request among `NSRC` requesters, such as DSP output, test tone and ADC loopback. On each frame it grants the highest-priority enabled, ready source, fetches one stereo sample from it, and returns the sample to the transmitter. Silence and a status pulse are substituted when no source can deliver.

---
 rtl/i2s_sched_pkg.sv | 18 +
 rtl/i2s_prio_enc.sv | 26 ++
 rtl/i2s_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_i2s_tx_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_sched_pkg.sv
// Shared types and helpers for the i2s transmit sample-source scheduler.
package i2s_sched_pkg;

    localparam int NSRC_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        RESP
    } sched_state_t;

    // Width of a source index; never zero so a single-source build still has a port.
    function automatic int sched_sw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_prio_enc.sv
// Lowest-index-wins priority encoder over NSRC request lines (combinational).
module i2s_prio_enc
    import i2s_sched_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]                req,
    output logic [sched_sw(NSRC)-1:0]      idx,
    output logic                           found
);

    localparam int SW = sched_sw(NSRC);

    // Scan downwards so the last hit, i.e. the lowest set index, wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = SW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_sched.sv
// Per-frame sample-source scheduler feeding the i2s_bi transmitter.
// Optional macro I2S_SCHED_TIMEOUT_EN adds a WAIT timeout that substitutes silence.
module i2s_tx_sched
    import i2s_sched_pkg::*;
#(
    parameter int DW      = 24,
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src_en,
    input  logic [NSRC-1:0]           src_req,
    output logic [NSRC-1:0]           src_rd_en,
    input  logic [NSRC-1:0]           src_rd_valid,
    input  logic [NSRC*DW-1:0]        src_ldata,
    input  logic [NSRC*DW-1:0]        src_rdata,
    input  logic                      tx_rd_en,
    output logic                      tx_rd_valid,
    output logic [DW-1:0]             tx_ldata,
    output logic [DW-1:0]             tx_rdata,
    output logic [sched_sw(NSRC)-1:0] grant,
    output logic                      grant_valid,
    output logic                      underrun,
    output logic                      req_overrun
);

    localparam int SW = sched_sw(NSRC);

    if (NSRC < 1 || NSRC > NSRC_MAX || TIMEOUT < 2) begin : g_bad_param
        $error("i2s_tx_sched: NSRC must be 1..16 and TIMEOUT at least 2");
    end

    sched_state_t      state, state_nx;
    logic              sil_pend, sil_pend_nx;
    logic [NSRC-1:0]   src_rd_en_nx;
    logic              tx_rd_valid_nx;
    logic [DW-1:0]     ldata_nx, rdata_nx;
    logic [SW-1:0]     grant_nx;
    logic              grant_valid_nx, underrun_nx, overrun_nx;

    logic [NSRC-1:0]   cand;
    logic [SW-1:0]     enc_idx;
    logic              enc_found;
    logic              sel_valid;
    logic [DW-1:0]     sel_l, sel_r;

`ifdef I2S_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]     cnt, cnt_nx;
`endif

    assign cand      = src_req & src_en;
    assign sel_valid = src_rd_valid[grant];
    assign sel_l     = src_ldata[int'(grant)*DW +: DW];
    assign sel_r     = src_rdata[int'(grant)*DW +: DW];

    i2s_prio_enc #(.NSRC(NSRC)) u_prio_enc (
        .req   (cand),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A silence frame spends one extra RESP cycle so underrun leads tx_rd_valid by one cycle.
    always_comb begin
        state_nx       = state;
        sil_pend_nx    = 1'b0;
        src_rd_en_nx   = '0;
        tx_rd_valid_nx = 1'b0;
        ldata_nx       = tx_ldata;
        rdata_nx       = tx_rdata;
        grant_nx       = grant;
        grant_valid_nx = grant_valid;
        underrun_nx    = 1'b0;
        overrun_nx     = tx_rd_en && (state != IDLE);
`ifdef I2S_SCHED_TIMEOUT_EN
        cnt_nx         = cnt;
`endif
        case (state)
            IDLE: begin
                if (tx_rd_en) begin
                    if (enc_found) begin
                        grant_nx       = enc_idx;
                        grant_valid_nx = 1'b1;
                        src_rd_en_nx   = NSRC'(1) << enc_idx;
                        state_nx       = FETCH;
                    end else begin
                        ldata_nx       = '0;
                        rdata_nx       = '0;
                        grant_valid_nx = 1'b0;
                        underrun_nx    = 1'b1;
                        sil_pend_nx    = 1'b1;
                        state_nx       = RESP;
                    end
                end
            end
            FETCH: begin
`ifdef I2S_SCHED_TIMEOUT_EN
                cnt_nx = '0;
`endif
                if (sel_valid) begin
                    ldata_nx       = sel_l;
                    rdata_nx       = sel_r;
                    tx_rd_valid_nx = 1'b1;
                    state_nx       = RESP;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (sel_valid) begin
                    ldata_nx       = sel_l;
                    rdata_nx       = sel_r;
                    tx_rd_valid_nx = 1'b1;
                    state_nx       = RESP;
                end
`ifdef I2S_SCHED_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    ldata_nx       = '0;
                    rdata_nx       = '0;
                    grant_valid_nx = 1'b0;
                    underrun_nx    = 1'b1;
                    tx_rd_valid_nx = 1'b1;
                    state_nx       = RESP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                if (sil_pend) begin
                    tx_rd_valid_nx = 1'b1;
                    state_nx       = RESP;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sil_pend    <= 1'b0;
            src_rd_en   <= '0;
            tx_rd_valid <= 1'b0;
            tx_ldata    <= '0;
            tx_rdata    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            underrun    <= 1'b0;
            req_overrun <= 1'b0;
`ifdef I2S_SCHED_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            sil_pend    <= sil_pend_nx;
            src_rd_en   <= src_rd_en_nx;
            tx_rd_valid <= tx_rd_valid_nx;
            tx_ldata    <= ldata_nx;
            tx_rdata    <= rdata_nx;
            grant       <= grant_nx;
            grant_valid <= grant_valid_nx;
            underrun    <= underrun_nx;
            req_overrun <= overrun_nx;
`ifdef I2S_SCHED_TIMEOUT_EN
            cnt         <= cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Randomised bench for i2s_tx_sched: per-transaction outcome model and per-cycle comparison.
module tb_i2s_tx_sched;

    localparam int DW   = 24;
    localparam int NSRC = 4;
    localparam int TMO  = 8;
    localparam int MAXC = 4096;
`ifdef I2S_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NSRC-1:0]      src_en, src_req, src_rd_en, src_rd_valid;
    logic [NSRC*DW-1:0]   src_ldata, src_rdata;
    logic                 tx_rd_en, tx_rd_valid;
    logic [DW-1:0]        tx_ldata, tx_rdata;
    logic [1:0]           grant;
    logic                 grant_valid, underrun, req_overrun;

    i2s_tx_sched #(.DW(DW), .NSRC(NSRC), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_en       (src_en),
        .src_req      (src_req),
        .src_rd_en    (src_rd_en),
        .src_rd_valid (src_rd_valid),
        .src_ldata    (src_ldata),
        .src_rdata    (src_rdata),
        .tx_rd_en     (tx_rd_en),
        .tx_rd_valid  (tx_rd_valid),
        .tx_ldata     (tx_ldata),
        .tx_rdata     (tx_rdata),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .underrun     (underrun),
        .req_overrun  (req_overrun)
    );

    typedef struct {
        bit [3:0]  rden;
        bit        txv, ud, ov;
        bit [23:0] l, r;
        bit [1:0]  g;
        bit        gv;
    } exp_t;

    typedef struct {
        logic [3:0]  rden;
        logic        txv, ud, ov;
        logic [23:0] l, r;
        logic [1:0]  g;
        logic        gv;
    } act_t;

    exp_t ex  [MAXC];
    act_t act [MAXC];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int c, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            act[cyc].rden = src_rd_en;
            act[cyc].txv  = tx_rd_valid;
            act[cyc].ud   = underrun;
            act[cyc].ov   = req_overrun;
            act[cyc].l    = tx_ldata;
            act[cyc].r    = tx_rdata;
            act[cyc].g    = grant;
            act[cyc].gv   = grant_valid;
            cmp("src_rd_en",   cyc, 32'(src_rd_en),   32'(ex[cyc].rden));
            cmp("tx_rd_valid", cyc, 32'(tx_rd_valid), 32'(ex[cyc].txv));
            cmp("underrun",    cyc, 32'(underrun),    32'(ex[cyc].ud));
            cmp("req_overrun", cyc, 32'(req_overrun), 32'(ex[cyc].ov));
            cmp("tx_ldata",    cyc, 32'(tx_ldata),    32'(ex[cyc].l));
            cmp("tx_rdata",    cyc, 32'(tx_rdata),    32'(ex[cyc].r));
            cmp("grant",       cyc, 32'(grant),       32'(ex[cyc].g));
            cmp("grant_valid", cyc, 32'(grant_valid), 32'(ex[cyc].gv));
        end
    end

    // One scheduler transaction starting at the current cycle. k: source latency after its
    // fetch strobe (-1 = never answers). ov_at: offset of an extra tx_rd_en (0 = random in
    // the busy window, -1 = none). rst_at: offset of a reset pulse. spur_at: offset where
    // every non-granted source asserts valid.
    task automatic txn(input logic [3:0] req, input logic [3:0] en, input int k,
                       input int ov_at_in, input int rst_at, input int spur_at,
                       input logic [23:0] ld, input logic [23:0] rd, output int t0);
        logic [3:0] cand;
        logic [3:0] v;
        int         g, e, last, qend, ov_at;
        bit         respond;
        cand    = req & en;
        g       = 0;
        for (int i = NSRC - 1; i >= 0; i--) if (cand[i]) g = i;
        respond = (cand != 0) && (k >= 0) && (!TMO_EN || k <= TMO);
        if (cand == 0)    e = 2;
        else if (respond) e = 2 + k;
        else              e = 2 + TMO;
        ov_at = (ov_at_in == 0) ? int'($urandom_range(1, e)) : ov_at_in;
        last  = (rst_at >= 0) ? k + 3 : e + 1;
        qend  = respond ? 1 + k : e - 1;
        t0    = cyc;

        if (cand == 0) begin
            ex[t0+1].ud  = 1'b1;
            ex[t0+2].txv = 1'b1;
            for (int i = t0 + 1; i < MAXC; i++) begin
                ex[i].l  = '0;
                ex[i].r  = '0;
                ex[i].gv = 1'b0;
            end
        end else begin
            ex[t0+1].rden = 4'b0001 << g;
            ex[t0+e].txv  = 1'b1;
            if (!respond) ex[t0+e].ud = 1'b1;
            for (int i = t0 + 1; i < MAXC; i++) begin
                ex[i].g  = 2'(g);
                ex[i].gv = 1'b1;
            end
            for (int i = t0 + e; i < MAXC; i++) begin
                ex[i].l  = respond ? ld : 24'h0;
                ex[i].r  = respond ? rd : 24'h0;
                ex[i].gv = respond;
            end
        end
        if (ov_at > 0) ex[t0+ov_at+1].ov = 1'b1;
        if (rst_at >= 0)
            for (int i = t0 + rst_at + 1; i < MAXC; i++) ex[i] = '{default: '0};

        for (int c = 0; c <= last; c++) begin
            tx_rd_en = (c == 0) || (c == ov_at);
            rst      = (c == rst_at);
            if (c == 0) begin
                src_req = req;
                src_en  = en;
            end else begin
                src_req = 4'($urandom);
                src_en  = 4'($urandom);
            end
            v = 4'($urandom);
            if (c == spur_at) v = 4'hF;
            if (cand != 0 && c >= 1 && c <= qend) v[g] = respond && (c == 1 + k);
            src_rd_valid = v;
            for (int s = 0; s < NSRC; s++) begin
                src_ldata[s*DW +: DW] = 24'($urandom);
                src_rdata[s*DW +: DW] = 24'($urandom);
            end
            if (cand != 0 && respond && c == 1 + k) begin
                src_ldata[g*DW +: DW] = ld;
                src_rdata[g*DW +: DW] = rd;
            end
            @(posedge clk);
            #1;
        end
        tx_rd_en     = 1'b0;
        rst          = 1'b0;
        src_rd_valid = '0;
    endtask

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst          = 1'b1;
        tx_rd_en     = 1'b0;
        src_en       = '0;
        src_req      = '0;
        src_rd_valid = '0;
        src_ldata    = '0;
        src_rdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        cmp("rst_txv",  2, 32'(act[2].txv),  32'd0);
        cmp("rst_rden", 2, 32'(act[2].rden), 32'd0);
        cmp("rst_l",    2, 32'(act[2].l),    32'd0);
        cmp("rst_gv",   2, 32'(act[2].gv),   32'd0);
        cmp("rst_ud",   2, 32'(act[2].ud),   32'd0);

        // Zero-wait source 1.
        txn(4'b0110, 4'b1111, 0, -1, -1, -1, 24'h123456, 24'hABCDEF, t0);
        cmp("t1_rden",  t0 + 1, 32'(act[t0+1].rden), 32'h2);
        cmp("t1_txv",   t0 + 2, 32'(act[t0+2].txv),  32'h1);
        cmp("t1_l",     t0 + 2, 32'(act[t0+2].l),    32'h123456);
        cmp("t1_r",     t0 + 2, 32'(act[t0+2].r),    32'hABCDEF);
        cmp("t1_grant", t0 + 2, 32'(act[t0+2].g),    32'h1);
        cmp("t1_txv3",  t0 + 3, 32'(act[t0+3].txv),  32'h0);

        // Source 1 masked off; its valid during WAIT must be ignored.
        txn(4'b0110, 4'b1101, 3, -1, -1, 2, 24'h0A0B0C, 24'h0D0E0F, t0);
        cmp("t2_rden",  t0 + 1, 32'(act[t0+1].rden), 32'h4);
        cmp("t2_txv4",  t0 + 4, 32'(act[t0+4].txv),  32'h0);
        cmp("t2_txv",   t0 + 5, 32'(act[t0+5].txv),  32'h1);
        cmp("t2_l",     t0 + 5, 32'(act[t0+5].l),    32'h0A0B0C);
        cmp("t2_grant", t0 + 5, 32'(act[t0+5].g),    32'h2);

        // No candidate: silence frame.
        txn(4'b0000, 4'b1111, 0, -1, -1, -1, 24'h0, 24'h0, t0);
        cmp("t3_ud",   t0 + 1, 32'(act[t0+1].ud),  32'h1);
        cmp("t3_txv1", t0 + 1, 32'(act[t0+1].txv), 32'h0);
        cmp("t3_txv",  t0 + 2, 32'(act[t0+2].txv), 32'h1);
        cmp("t3_l",    t0 + 2, 32'(act[t0+2].l),   32'h0);
        cmp("t3_gv",   t0 + 2, 32'(act[t0+2].gv),  32'h0);

`ifdef I2S_SCHED_TIMEOUT_EN
        txn(4'b0001, 4'b1111, -1, -1, -1, -1, 24'h0, 24'h0, t0);
        cmp("t4_rden", t0 + 1,  32'(act[t0+1].rden), 32'h1);
        cmp("t4_txv9", t0 + 9,  32'(act[t0+9].txv),  32'h0);
        cmp("t4_txv",  t0 + 10, 32'(act[t0+10].txv), 32'h1);
        cmp("t4_ud",   t0 + 10, 32'(act[t0+10].ud),  32'h1);
        cmp("t4_gv",   t0 + 10, 32'(act[t0+10].gv),  32'h0);
`else
        txn(4'b0001, 4'b1111, 20, -1, -1, -1, 24'h55AA55, 24'h33CC33, t0);
        cmp("t4_rden",  t0 + 1,  32'(act[t0+1].rden), 32'h1);
        cmp("t4_txv21", t0 + 21, 32'(act[t0+21].txv), 32'h0);
        cmp("t4_txv",   t0 + 22, 32'(act[t0+22].txv), 32'h1);
        cmp("t4_l",     t0 + 22, 32'(act[t0+22].l),   32'h55AA55);
        cmp("t4_ud",    t0 + 22, 32'(act[t0+22].ud),  32'h0);
`endif

        // Second request during WAIT.
        txn(4'b1010, 4'b1111, 5, 3, -1, -1, 24'hFEDCBA, 24'h987654, t0);
        cmp("t5_ov",  t0 + 4, 32'(act[t0+4].ov),  32'h1);
        cmp("t5_txv", t0 + 7, 32'(act[t0+7].txv), 32'h1);
        cmp("t5_r",   t0 + 7, 32'(act[t0+7].r),   32'h987654);

        // Reset while waiting; the late valid must not complete a frame.
        txn(4'b1000, 4'b1111, 5, -1, 3, -1, 24'h777777, 24'h888888, t0);
        cmp("t6_grant_pre", t0 + 3, 32'(act[t0+3].g),    32'h3);
        cmp("t6_gv",        t0 + 4, 32'(act[t0+4].gv),   32'h0);
        cmp("t6_grant",     t0 + 4, 32'(act[t0+4].g),    32'h0);
        cmp("t6_l",         t0 + 4, 32'(act[t0+4].l),    32'h0);
        for (int c = t0 + 4; c <= t0 + 8; c++)
            cmp("t6_no_txv", c, 32'(act[c].txv), 32'h0);

        for (int n = 0; n < 150 && cyc < MAXC - 64; n++) begin
            logic [3:0] rq, en;
            int         k, ov;
            rq = 4'($urandom);
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            k  = TMO_EN ? int'($urandom_range(0, TMO + 3)) : int'($urandom_range(0, 12));
            if (TMO_EN && k > TMO) k = -1;
            ov = ($urandom_range(0, 2) == 0) ? 0 : -1;
            txn(rq, en, k, ov, -1, ($urandom_range(0, 3) == 0) ? 2 : -1,
                24'($urandom), 24'($urandom), t0);
            repeat ($urandom_range(0, 2)) begin
                src_rd_valid = 4'($urandom);
                @(posedge clk);
                #1;
            end
            src_rd_valid = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
